// File: rtl/fb_sched_pkg.sv
// Shared types and helpers for the framebuffer source scheduler.
// Holds the scheduler state encoding and the overlay colour conversion.
package fb_sched_pkg;

    localparam int FB_W_BITS   = 9;
    localparam int FB_H_BITS   = 8;
    localparam int DISP_W_BITS = 11;

    typedef enum logic [1:0] {
        S_GBA    = 2'd0,
        S_TO_OVL = 2'd1,
        S_OVL    = 2'd2,
        S_TO_GBA = 2'd3
    } sched_state_t;

    // BGR5 {x,B,G,R} widened to RGB6 by a zero LSB per channel
    function automatic logic [17:0] bgr5_to_rgb6(input logic [15:0] c);
        return {c[4:0], 1'b0, c[9:5], 1'b0, c[14:10], 1'b0};
    endfunction

endpackage

// File: rtl/ovl_scan_gen.sv
// Overlay raster walker: per-pixel cycle counter plus x/y scan position.
// Emits sample, write and frame-start strobes while enabled.
module ovl_scan_gen #(
    parameter int W       = 256,
    parameter int H       = 224,
    parameter int PIX_CYC = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       restart,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       we,
    output logic       sample,
    output logic       vsync,
    output logic       frame_end
);

    localparam int CW = $clog2(PIX_CYC);
    localparam logic [CW-1:0] C_LAST = CW'(PIX_CYC - 1);
    localparam logic [CW-1:0] C_SAMP = CW'(PIX_CYC - 6);
    localparam logic [7:0] X_LAST = 8'(W - 1);
    localparam logic [7:0] Y_LAST = 8'(H - 1);

    logic [CW-1:0] cnt;

    assign we        = en && (cnt == C_LAST);
    assign sample    = en && (cnt == C_SAMP);
    assign vsync     = en && (cnt == '0) && (x == 8'd0) && (y == 8'd0);
    assign frame_end = we && (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            x   <= '0;
            y   <= '0;
        end else if (restart) begin
            cnt <= '0;
            x   <= '0;
            y   <= '0;
        end else if (en) begin
            cnt <= (cnt == C_LAST) ? '0 : cnt + 1'b1;
            if (we) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 8'd1;
                end else begin
                    x <= x + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fb_source_sched.sv
// Owns the framebuffer write port, switching between GBA and overlay
// sources on frame boundaries (or timeout) and driving geometry config.
module fb_source_sched
    import fb_sched_pkg::*;
#(
    parameter int GBA_W       = 240,
    parameter int GBA_H       = 160,
    parameter int OVL_W       = 256,
    parameter int OVL_H       = 224,
    parameter int OVL_PIX_CYC = 16,
    parameter int GBA_DISP_W  = 1080,
    parameter int OVL_DISP_W  = 960,
    parameter int SW_TIMEOUT  = 1048576
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   overlay_req,
    input  logic                   freeze,
    input  logic [17:0]            gba_data,
    input  logic [7:0]             gba_x,
    input  logic [7:0]             gba_y,
    input  logic                   gba_we,
    output logic [7:0]             ovl_x,
    output logic [7:0]             ovl_y,
    input  logic [15:0]            ovl_color,
    output logic                   mode,
    output logic                   switch_pending,
    output logic [FB_W_BITS-1:0]   fb_width,
    output logic [FB_H_BITS-1:0]   fb_height,
    output logic [DISP_W_BITS-1:0] disp_width,
    output logic                   fb_vsync,
    output logic                   fb_we,
    output logic [17:0]            fb_data
);

    localparam int TW = $clog2(SW_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(SW_TIMEOUT - 1);

    sched_state_t state, state_nx;
    logic [TW-1:0] to_cnt;
    logic ovl_mode, gba_end, ovl_end, timed_out;
    logic ovl_en, restart;
    logic s_we, s_sample, s_vsync;
    logic gba_vs_pend, entry_vs_pend;

    assign ovl_mode       = (state == S_OVL) || (state == S_TO_GBA);
    assign switch_pending = (state == S_TO_OVL) || (state == S_TO_GBA);
    assign mode           = ovl_mode;

    assign fb_width   = ovl_mode ? FB_W_BITS'(OVL_W) : FB_W_BITS'(GBA_W);
    assign fb_height  = ovl_mode ? FB_H_BITS'(OVL_H) : FB_H_BITS'(GBA_H);
    assign disp_width = ovl_mode ? DISP_W_BITS'(OVL_DISP_W)
                                 : DISP_W_BITS'(GBA_DISP_W);

    assign gba_end = !freeze && !ovl_mode && gba_we
                   && (gba_x == 8'(GBA_W - 1))
                   && (gba_y == 8'(GBA_H - 1));
    assign timed_out = (to_cnt == T_LAST);
    assign ovl_en    = ovl_mode && !freeze;
    assign restart   = (state == S_TO_OVL) && (state_nx == S_OVL);

    ovl_scan_gen #(
        .W       (OVL_W),
        .H       (OVL_H),
        .PIX_CYC (OVL_PIX_CYC)
    ) u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .en        (ovl_en),
        .restart   (restart),
        .x         (ovl_x),
        .y         (ovl_y),
        .we        (s_we),
        .sample    (s_sample),
        .vsync     (s_vsync),
        .frame_end (ovl_end)
    );

    // A request returning to the origin value cancels before any boundary
    always_comb begin
        state_nx = state;
        if (!freeze) begin
            unique case (state)
                S_GBA:    if (overlay_req) state_nx = S_TO_OVL;
                S_TO_OVL: begin
                    if (!overlay_req)               state_nx = S_GBA;
                    else if (gba_end || timed_out)  state_nx = S_OVL;
                end
                S_OVL:    if (!overlay_req) state_nx = S_TO_GBA;
                S_TO_GBA: begin
                    if (overlay_req)                state_nx = S_OVL;
                    else if (ovl_end || timed_out)  state_nx = S_GBA;
                end
                default:  state_nx = S_GBA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_GBA;
            to_cnt        <= '0;
            gba_vs_pend   <= 1'b0;
            entry_vs_pend <= 1'b0;
            fb_vsync      <= 1'b0;
            fb_we         <= 1'b0;
            fb_data       <= '0;
        end else begin
            state <= state_nx;
            if (!freeze) begin
                if (switch_pending && (state_nx == state))
                    to_cnt <= to_cnt + 1'b1;
                else
                    to_cnt <= '0;
            end
            gba_vs_pend   <= gba_end;
            entry_vs_pend <= (state == S_TO_GBA) && (state_nx == S_GBA);
            fb_vsync <= !freeze && (gba_vs_pend || entry_vs_pend || s_vsync);
            if (ovl_mode) begin
                fb_we <= s_we;
                if (s_sample) fb_data <= bgr5_to_rgb6(ovl_color);
            end else begin
                fb_we <= gba_we && !freeze;
                if (gba_we && !freeze) fb_data <= gba_data;
            end
        end
    end

endmodule
